// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared defaults and stage record for the post-arithmetic normalizer
package fp_norm_pkg;
    localparam int XLEN_DEF = 64;
    localparam int XLOG_DEF = 6;
    localparam int ELEN_DEF = 13;

    typedef struct packed {
        logic [XLEN_DEF-1:0] mant;
        logic [ELEN_DEF-1:0] exp;
        logic [XLOG_DEF-1:0] lz;
        logic                v;
        logic                sign;
    } stage_t;
endpackage

// File: rtl/fp_norm_lzc.sv
// rtl/fp_norm_lzc.sv - leading-one locator: c is the index of the top set bit, v flags a nonzero input
module fp_norm_lzc #(
    parameter int XLEN = 64,
    parameter int XLOG = 6
) (
    input  logic [XLEN-1:0] a,
    output logic [XLOG-1:0] c,
    output logic            v
);
    // Ascending scan so the highest set bit wins; c stays 0 for a zero input.
    always_comb begin
        c = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (a[i]) c = XLOG'(i);
        end
        v = |a;
    end
endmodule

// File: rtl/fp_norm.sv
// rtl/fp_norm.sv - two-stage mantissa normalizer with exponent adjust and valid/ready backpressure
module fp_norm
    import fp_norm_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int XLOG = XLOG_DEF,
    parameter int ELEN = ELEN_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_mant,
    input  logic [ELEN-1:0] in_exp,
    input  logic            in_sign,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_mant,
    output logic [ELEN-1:0] out_exp,
    output logic            out_sign,
    output logic            out_zero
);
    logic [XLOG-1:0] lzc_c;
    logic            lzc_v;

    generate
        if (XLEN == 4 || XLEN == 8 || XLEN == 16 || XLEN == 32 ||
            XLEN == 64 || XLEN == 128 || XLEN == 256) begin : g_lzc
            fp_norm_lzc #(.XLEN(XLEN), .XLOG(XLOG)) u_lzc (
                .a (in_mant),
                .c (lzc_c),
                .v (lzc_v)
            );
        end
    endgenerate

    logic            s1_valid_q;
    logic [XLEN-1:0] s1_mant_q;
    logic [ELEN-1:0] s1_exp_q;
    logic [XLOG-1:0] s1_lz_q;
    logic            s1_v_q;
    logic            s1_sign_q;

    logic            s2_valid_q;
    logic [XLEN-1:0] s2_mant_q, s2_mant_d;
    logic [ELEN-1:0] s2_exp_q, s2_exp_d;
    logic            s2_sign_q;
    logic            s2_zero_q;

    logic adv1, adv2;

    always_comb begin
        adv2     = ~s2_valid_q | out_ready;
        adv1     = ~s1_valid_q | adv2;
        in_ready = adv1 & ~reset;
    end

    // Exponent subtract wraps in ELEN bits; underflow is left for rounding to detect.
    always_comb begin
        s2_mant_d = '0;
        s2_exp_d  = '0;
        if (s1_v_q) begin
            s2_mant_d = s1_mant_q << s1_lz_q;
            s2_exp_d  = s1_exp_q - {{(ELEN-XLOG){1'b0}}, s1_lz_q};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_lz_q    <= '0;
            s1_v_q     <= 1'b0;
            s1_sign_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_exp_q   <= '0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
        end else begin
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_mant_q <= s2_mant_d;
                    s2_exp_q  <= s2_exp_d;
                    s2_sign_q <= s1_sign_q;
                    s2_zero_q <= ~s1_v_q;
                end
            end
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_mant_q <= in_mant;
                    s1_exp_q  <= in_exp;
                    s1_lz_q   <= ~lzc_c;
                    s1_v_q    <= lzc_v;
                    s1_sign_q <= in_sign;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_mant  = s2_mant_q;
    assign out_exp   = s2_exp_q;
    assign out_sign  = s2_sign_q;
    assign out_zero  = s2_zero_q;
endmodule

// File: tb/tb_fp_norm.sv
// tb/tb_fp_norm.sv - randomized scoreboard bench for fp_norm at XLEN=64, ELEN=13
module tb_fp_norm;
    import fp_norm_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_mant;
    logic [12:0] in_exp;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_mant;
    logic [12:0] out_exp;
    logic        out_sign;
    logic        out_zero;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    int n_stall  = 0;
    stage_t sb[$];

    always #5 clock = ~clock;

    fp_norm #(.XLEN(64), .XLOG(6), .ELEN(13)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_zero  (out_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    // Normalize by shifting one bit at a time until the MSB is set.
    function automatic stage_t model(input logic [63:0] m, input logic [12:0] e, input logic s);
        stage_t r;
        r.mant = m;
        r.exp  = e;
        r.sign = s;
        r.v    = (m != 64'd0);
        r.lz   = '0;
        if (!r.v) begin
            r.exp = '0;
            return r;
        end
        while (!r.mant[63]) begin
            r.mant = r.mant << 1;
            r.exp  = r.exp - 13'd1;
            r.lz   = r.lz + 6'd1;
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    stage_t e;
                    e = sb.pop_front();
                    check("mant", out_mant, e.mant);
                    check("exp", 64'(out_exp), 64'(e.exp));
                    check("sign", 64'(out_sign), 64'(e.sign));
                    check("zero", 64'(out_zero), 64'(!e.v));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_mant, in_exp, in_sign));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [63:0] m, input logic [12:0] e, input logic s);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        in_sign  = s;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clock);
            ok = in_ready;
            if (!ok) n_stall++;
            @(posedge clock);
            #1;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int base;
        int stall0;
        bit done;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_mant", out_mant, 64'd0);
        check("rst_out_exp", 64'(out_exp), 64'd0);
        check("rst_out_sign", 64'(out_sign), 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single beats with fixed expectations and two-cycle latency.
        out_ready = 1'b1;
        send(64'd1, 13'd0, 1'b0);
        check("lat_not_early", 64'(out_valid), 64'd0);
        tick();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_mant", out_mant, 64'h8000_0000_0000_0000);
        check("t1_exp", 64'(out_exp), 64'h1FC1);
        check("t1_zero", 64'(out_zero), 64'd0);

        send(64'h8000_0000_0000_0000, 13'd5, 1'b1);
        tick();
        check("t2_mant", out_mant, 64'h8000_0000_0000_0000);
        check("t2_exp", 64'(out_exp), 64'd5);
        check("t2_sign", 64'(out_sign), 64'd1);

        send(64'd0, 13'd100, 1'b0);
        tick();
        check("t3_mant", out_mant, 64'd0);
        check("t3_exp", 64'(out_exp), 64'd0);
        check("t3_zero", 64'(out_zero), 64'd1);
        repeat (2) tick();

        // Walking one, streamed with no bubbles.
        base   = n_out;
        stall0 = n_stall;
        for (int i = 0; i < 64; i++) send(64'd1 << i, 13'd0, 1'b0);
        check("walk_no_stall", 64'(n_stall - stall0), 64'd0);
        check("walk_streamed", 64'(n_out - base), 64'd62);
        repeat (2) tick();
        check("walk_count", 64'(n_out - base), 64'd64);

        // Backpressure: two beats fill the pipe, the rest wait.
        base      = n_out;
        out_ready = 1'b0;
        send(64'h0000_00F0_0000_0000, 13'd10, 1'b0);
        send(64'h0000_0000_0000_0003, 13'd20, 1'b1);
        in_valid = 1'b1;
        in_mant  = 64'h0123_4567_89AB_CDEF;
        in_exp   = 13'd30;
        in_sign  = 1'b0;
        check("full_in_ready_a", 64'(in_ready), 64'd0);
        tick();
        check("full_in_ready_b", 64'(in_ready), 64'd0);
        tick();
        check("full_no_out", 64'(n_out - base), 64'd0);
        out_ready = 1'b1;
        send(64'h0123_4567_89AB_CDEF, 13'd30, 1'b0);
        send(64'h0000_0000_0001_0000, 13'h1FF0, 1'b1);
        repeat (3) tick();
        check("bp_count", 64'(n_out - base), 64'd4);

        // Reset with both stages full discards in-flight beats.
        out_ready = 1'b0;
        send(64'h0000_0000_0000_00AA, 13'd1, 1'b0);
        send(64'h0000_0000_0000_0055, 13'd2, 1'b1);
        base  = n_out;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (5) tick();
        check("mid_rst_no_stale", 64'(n_out - base), 64'd0);

        // Randomized traffic with random backpressure.
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    logic [63:0] r;
                    r = {$urandom(), $urandom()};
                    r = r >> $urandom_range(0, 64);
                    send(r, 13'($urandom()), 1'($urandom()));
                    if ($urandom_range(0, 3) == 0) tick();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_norm.md
# fp_norm

Pipelined post-arithmetic normalizer for the FPU datapath. It sits directly downstream of the add/sub and fused-multiply-add mantissa stages and directly upstream of rounding. It takes an unnormalized mantissa with its exponent, counts leading zeros with the existing `lzc_<XLEN>` counter, left-shifts the mantissa so its MSB is set, and adjusts the exponent. It has two register stages with valid/ready handshakes on both sides and full backpressure.

## Interface
- `XLEN`, default 64: mantissa width. Legal values are 4, 8, 16, 32, 64, 128 and 256.
- `XLOG`, default 6: equals log2(XLEN), and is also the width of the lzc count.
- `ELEN`, default 13: exponent width, two's complement.

Ports (name, direction, width, meaning):
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: stage 1 can accept.
- `in_mant` input XLEN: unnormalized mantissa.
- `in_exp` input ELEN: signed exponent.
- `in_sign` input 1: sign, passed through unchanged.
- `out_valid` output 1: result present.
- `out_ready` input 1: rounding stage accepts.
- `out_mant` output XLEN: normalized mantissa.
- `out_exp` output ELEN: adjusted exponent.
- `out_sign` output 1: sign.
- `out_zero` output 1: input mantissa was zero.

## Operation
- lzc contract:
  - `lzc_<XLEN>` output `c` is the bit index of the most-significant set bit.
  - The leading-zero count is `lz = ~c` (XLOG bits).
  - `v` = 1 iff `a` != 0.
- Stage 1 (S1):
  - On accept, registers mant, exp and sign.
  - Also registers `lz` and `v`, computed combinationally from `in_mant`.
- Stage 2 (S2): on advance from S1, registers:
  - `out_mant = s1_mant << s1_lz`
  - `out_exp = s1_exp - zero_extend(s1_lz)`, computed in ELEN bits and wrapping modulo 2^ELEN. There is no saturation; the rounding stage detects underflow.
  - `out_sign = s1_sign`
  - `out_zero = ~s1_v`
- Zero mantissa (`v` = 0): `out_mant` = 0, `out_exp` = 0, `out_zero` = 1, `out_sign` passed through.
- Handshake:
  - A beat transfers on either side when valid && ready.
  - Once valid is asserted, the producer holds valid and data stable until ready.
  - `adv2 = ~s2_valid | out_ready`
  - `adv1 = ~s1_valid | adv2`
  - `in_ready = adv1 & ~reset`
  - S1 moves into S2 when `s1_valid & adv2`.
  - S1 loads from the input when `in_valid & in_ready`.
  - Otherwise each stage holds its contents.
- Ordering: strict FIFO. Beats are never dropped or duplicated.
- Reset mid-operation: both stage valids clear at the next edge. In-flight beats are discarded, and no output beat appears from pre-reset input.

## Timing
- Latency is 2 cycles from input accept to `out_valid` when `out_ready` = 1.
- Throughput is 1 beat/cycle with no bubbles while `out_ready` = 1.
- Capacity is 2 beats. With `out_ready` held 0, `in_ready` falls after S1 and S2 are both full.
- Reset values:
  - `out_valid` = 0, `out_mant` = 0, `out_exp` = 0, `out_sign` = 0, `out_zero` = 0.
  - Internal `s1_valid` = 0.
  - `in_ready` = 0 while `reset` is high, and 1 in the first cycle after.
- All outputs except `in_ready` are registered. `in_ready` has a combinational path from `out_ready`, accepted as one level of logic.
- Simultaneous accept and emit in the same cycle with both stages full is legal and keeps occupancy constant.

## Structure
- Shared package `fp_norm_pkg`:
  - stage record struct (`mant`, `exp`, `lz`, `v`, `sign`), parameterized by the defaults;
  - constants `XLEN_DEF`, `XLOG_DEF`, `ELEN_DEF`.
- One sub-module: the existing `lzc_<XLEN>`, selected by a generate on XLEN.
- The barrel shift and exponent subtract are written inline in the S2 register logic; there is no separate module.

## Test plan
All scenarios use XLEN = 64, XLOG = 6, ELEN = 13.
1. `in_mant` = 0x1, `in_exp` = 0, `out_ready` = 1 → two cycles later `out_mant` = 0x8000_0000_0000_0000, `out_exp` = -63, `out_zero` = 0.
2. `in_mant` = 0x8000_0000_0000_0000, `in_exp` = 5, `in_sign` = 1 → `out_mant` unchanged, `out_exp` = 5, `out_sign` = 1.
3. `in_mant` = 0, `in_exp` = 100 → `out_mant` = 0, `out_exp` = 0, `out_zero` = 1.
4. Walking one, bit i = 0..63 back-to-back, `in_exp` = 0 → every output has `out_mant` = MSB only and `out_exp` = i - 63, in order, one per cycle.
5. Four back-to-back beats with `out_ready` = 0 for 4 cycles:
   - `in_ready` = 0 after 2 beats are accepted;
   - after `out_ready` = 1, all 4 beats emerge in order with none lost.
6. Assert `reset` for 1 cycle while both stages are full → `out_valid` = 0 next cycle, and no stale beat appears afterwards.
